writeback_unit: RTL and testbench

- Writer side of the integer register file.
- Collects results from the ALU (no backpressure) and the load/store unit (valid/ready), queues load results behind ALU writes, and drives one registered write per cycle onto the regfile write port (rd_address, rd_data).
- Keeps a 32-bit pending-write scoreboard so issue logic can detect RAW hazards on rs1/rs2.

---
 rtl/writeback_unit_pkg.sv | 20 ++
 rtl/wb_queue.sv | 71 +++++++
 rtl/writeback_unit.sv | 134 +++++++++++++
 tb/tb_writeback_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the register-file writeback slice: register
// address width, the x0 constant, and the per-cycle source-select encoding.
package writeback_unit_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_ALU   = 2'd1,
        SEL_QUEUE = 2'd2,
        SEL_MEM   = 2'd3
    } wb_sel_e;

    // True when the address names the hardwired-zero register.
    function automatic logic is_reg_zero(input logic [REG_ADDR_W-1:0] addr);
        return (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_queue.sv
// Parameterised synchronous FIFO holding load results that could not be
// written back in the cycle they were accepted. DEPTH must be a power of
// two so the pointers wrap naturally.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full     = (count_r == CNT_FULL);
    assign empty    = (count_r == {CNT_W{1'b0}});
    assign count    = count_r;
    assign pop_data = mem_r[rd_ptr_r];

    // Guard against overflow/underflow even if the caller misbehaves.
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writer side of the integer register file. Merges ALU results (no
// backpressure) with load results (valid/ready, queued behind ALU writes),
// registers one write per cycle onto the regfile port, and keeps a
// pending-write scoreboard for RAW hazard detection at issue.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int MEM_DEPTH = 4,
    parameter int XLEN      = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    input  logic [4:0]                   issue_rd_address,
    input  logic                         alu_valid,
    input  logic [4:0]                   alu_rd_address,
    input  logic [XLEN-1:0]              alu_data,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [4:0]                   mem_rd_address,
    input  logic [XLEN-1:0]              mem_data,
    output logic [4:0]                   rd_address,
    output logic [XLEN-1:0]              rd_data,
    input  logic [4:0]                   rs1_address,
    input  logic [4:0]                   rs2_address,
    output logic                         rs1_pending,
    output logic                         rs2_pending,
    output logic [$clog2(MEM_DEPTH):0]   queue_count
);

    localparam int CNT_W   = $clog2(MEM_DEPTH) + 1;
    localparam int ENTRY_W = REG_ADDR_W + XLEN;

    logic                  q_full_s;
    logic                  q_empty_s;
    logic                  q_push_s;
    logic                  q_pop_s;
    logic [ENTRY_W-1:0]    q_head_s;
    logic [CNT_W-1:0]      q_count_s;
    logic                  mem_accept_s;
    wb_sel_e               sel_s;
    logic [REG_ADDR_W-1:0] wb_addr_s;
    logic [XLEN-1:0]       wb_data_s;
    logic [31:0]           pending_r;
    logic [31:0]           pending_next_s;

    wb_queue #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push_s),
        .push_data ({mem_rd_address, mem_data}),
        .pop       (q_pop_s),
        .pop_data  (q_head_s),
        .full      (q_full_s),
        .empty     (q_empty_s),
        .count     (q_count_s)
    );

    // Ready depends only on occupancy (no pass-through when full).
    assign mem_ready    = rst_n && !q_full_s;
    assign mem_accept_s = mem_valid && mem_ready;
    assign queue_count  = q_count_s;

    // Source select: ALU first, then queue head, then a direct load bypass.
    always_comb begin
        sel_s     = SEL_NONE;
        wb_addr_s = REG_ZERO;
        wb_data_s = rd_data;
        if (alu_valid) begin
            sel_s     = SEL_ALU;
            wb_addr_s = alu_rd_address;
            wb_data_s = alu_data;
        end else if (!q_empty_s) begin
            sel_s     = SEL_QUEUE;
            wb_addr_s = q_head_s[ENTRY_W-1:XLEN];
            wb_data_s = q_head_s[XLEN-1:0];
        end else if (mem_accept_s && !is_reg_zero(mem_rd_address)) begin
            sel_s     = SEL_MEM;
            wb_addr_s = mem_rd_address;
            wb_data_s = mem_data;
        end else begin
            sel_s     = SEL_NONE;
        end
    end

    // Loads to x0 are swallowed; other accepted loads not bypassed are queued.
    always_comb begin
        q_push_s = mem_accept_s && (sel_s != SEL_MEM) && !is_reg_zero(mem_rd_address);
        q_pop_s  = (sel_s == SEL_QUEUE);
    end

    // Registered regfile write port; data holds when no write is selected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_address <= REG_ZERO;
            rd_data    <= {XLEN{1'b0}};
        end else begin
            rd_address <= wb_addr_s;
            rd_data    <= wb_data_s;
        end
    end

    // Scoreboard update: commit clears, a same-cycle issue to the same reg wins.
    always_comb begin
        pending_next_s = pending_r;
        if (!is_reg_zero(rd_address)) begin
            pending_next_s[rd_address] = 1'b0;
        end else begin
            pending_next_s = pending_next_s;
        end
        if (issue_valid && !is_reg_zero(issue_rd_address)) begin
            pending_next_s[issue_rd_address] = 1'b1;
        end else begin
            pending_next_s = pending_next_s;
        end
        pending_next_s[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_r <= 32'h0000_0000;
        end else begin
            pending_r <= pending_next_s;
        end
    end

    assign rs1_pending = pending_r[rs1_address];
    assign rs2_pending = pending_r[rs2_address];

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
module tb_writeback_unit;

    localparam int XLEN      = 32;
    localparam int MEM_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rd_address;
    logic        alu_valid;
    logic [4:0]  alu_rd_address;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd_address;
    logic [31:0] mem_data;
    logic [4:0]  rd_address;
    logic [31:0] rd_data;
    logic [4:0]  rs1_address;
    logic [4:0]  rs2_address;
    logic        rs1_pending;
    logic        rs2_pending;
    logic [2:0]  queue_count;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_unit #(.MEM_DEPTH(MEM_DEPTH), .XLEN(XLEN)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .issue_valid      (issue_valid),
        .issue_rd_address (issue_rd_address),
        .alu_valid        (alu_valid),
        .alu_rd_address   (alu_rd_address),
        .alu_data         (alu_data),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_rd_address   (mem_rd_address),
        .mem_data         (mem_data),
        .rd_address       (rd_address),
        .rd_data          (rd_data),
        .rs1_address      (rs1_address),
        .rs2_address      (rs2_address),
        .rs1_pending      (rs1_pending),
        .rs2_pending      (rs2_pending),
        .queue_count      (queue_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; issue_valid = 1'b0; issue_rd_address = 5'd0;
        alu_valid = 1'b0; alu_rd_address = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd_address = 5'd0; mem_data = 32'd0;
        rs1_address = 5'd0; rs2_address = 5'd0;
        step(); step();
        n_checks++; if (rd_address !== 5'd0) begin n_fail++; $display("FAIL reset_rd_address: got %0d expected 0", rd_address); end
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
        n_checks++; if (queue_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", queue_count); end
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready_low: got %0b expected 0", mem_ready); end
        rst_n = 1'b1;
        step();
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %0b expected 1", mem_ready); end
    endtask

    task automatic test_alu_write();
        rs1_address = 5'd5;
        issue_valid = 1'b1; issue_rd_address = 5'd5;
        step();
        issue_valid = 1'b0;
        n_checks++; if (rs1_pending !== 1'b1) begin n_fail++; $display("FAIL alu_pending_set: got %0b expected 1", rs1_pending); end
        alu_valid = 1'b1; alu_rd_address = 5'd5; alu_data = 32'h0000_1234;
        step();
        alu_valid = 1'b0;
        n_checks++; if (rd_address !== 5'd5) begin n_fail++; $display("FAIL alu_rd_address: got %0d expected 5", rd_address); end
        n_checks++; if (rd_data !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_rd_data: got %0h expected 1234", rd_data); end
        n_checks++; if (rs1_pending !== 1'b1) begin n_fail++; $display("FAIL alu_pending_until_commit: got %0b expected 1", rs1_pending); end
        step();
        n_checks++; if (rd_address !== 5'd0) begin n_fail++; $display("FAIL alu_idle_rd_address: got %0d expected 0", rd_address); end
        n_checks++; if (rd_data !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_idle_rd_data_hold: got %0h expected 1234", rd_data); end
        n_checks++; if (rs1_pending !== 1'b0) begin n_fail++; $display("FAIL alu_pending_cleared: got %0b expected 0", rs1_pending); end
    endtask

    task automatic test_load_bypass();
        mem_valid = 1'b1; mem_rd_address = 5'd7; mem_data = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL bypass_ready: got %0b expected 1", mem_ready); end
        step();
        mem_valid = 1'b0;
        n_checks++; if (rd_address !== 5'd7) begin n_fail++; $display("FAIL bypass_rd_address: got %0d expected 7", rd_address); end
        n_checks++; if (rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_rd_data: got %0h expected deadbeef", rd_data); end
        n_checks++; if (queue_count !== 3'd0) begin n_fail++; $display("FAIL bypass_count: got %0d expected 0", queue_count); end
        step();
        n_checks++; if (rd_address !== 5'd0) begin n_fail++; $display("FAIL bypass_single_write: got %0d expected 0", rd_address); end
    endtask

    task automatic test_queue_fill();
        int k;
        logic exp_ready;
        logic [2:0] exp_cnt;
        int exp_drain[6];
        exp_drain = '{3, 3, 3, 2, 1, 0};
        k = 1;
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1'b1; alu_rd_address = 5'(10 + i); alu_data = 32'h0000_00A0 + 32'(i);
            mem_valid = 1'b1; mem_rd_address = 5'(k); mem_data = 32'h0000_00B0 + 32'(k);
            exp_ready = (i < 4);
            #1;
            n_checks++; if (mem_ready !== exp_ready) begin n_fail++; $display("FAIL fill_ready[%0d]: got %0b expected %0b", i, mem_ready, exp_ready); end
            step();
            exp_cnt = (i < 4) ? 3'(i + 1) : 3'd4;
            n_checks++; if (rd_address !== 5'(10 + i)) begin n_fail++; $display("FAIL fill_alu_rd[%0d]: got %0d expected %0d", i, rd_address, 10 + i); end
            n_checks++; if (rd_data !== 32'h0000_00A0 + 32'(i)) begin n_fail++; $display("FAIL fill_alu_data[%0d]: got %0h expected %0h", i, rd_data, 32'h0000_00A0 + 32'(i)); end
            n_checks++; if (queue_count !== exp_cnt) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, queue_count, exp_cnt); end
            if (exp_ready) k++;
        end
        alu_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (k <= 6) begin
                mem_valid = 1'b1; mem_rd_address = 5'(k); mem_data = 32'h0000_00B0 + 32'(k);
            end else begin
                mem_valid = 1'b0;
            end
            exp_ready = (j != 0);
            #1;
            if (k <= 6) begin
                n_checks++; if (mem_ready !== exp_ready) begin n_fail++; $display("FAIL drain_ready[%0d]: got %0b expected %0b", j, mem_ready, exp_ready); end
            end
            step();
            n_checks++; if (rd_address !== 5'(j + 1)) begin n_fail++; $display("FAIL drain_order[%0d]: got %0d expected %0d", j, rd_address, j + 1); end
            n_checks++; if (rd_data !== 32'h0000_00B0 + 32'(j + 1)) begin n_fail++; $display("FAIL drain_data[%0d]: got %0h expected %0h", j, rd_data, 32'h0000_00B0 + 32'(j + 1)); end
            n_checks++; if (queue_count !== 3'(exp_drain[j])) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d expected %0d", j, queue_count, exp_drain[j]); end
            if (k <= 6 && exp_ready) k++;
        end
        mem_valid = 1'b0;
    endtask

    task automatic test_collision();
        rs2_address = 5'd9;
        issue_valid = 1'b1; issue_rd_address = 5'd9;
        step();
        issue_valid = 1'b0;
        n_checks++; if (rs2_pending !== 1'b1) begin n_fail++; $display("FAIL coll_pending_set: got %0b expected 1", rs2_pending); end
        alu_valid = 1'b1; alu_rd_address = 5'd9; alu_data = 32'h0000_0099;
        step();
        alu_valid = 1'b0;
        n_checks++; if (rd_address !== 5'd9) begin n_fail++; $display("FAIL coll_rd_address: got %0d expected 9", rd_address); end
        issue_valid = 1'b1; issue_rd_address = 5'd9;
        step();
        issue_valid = 1'b0;
        n_checks++; if (rs2_pending !== 1'b1) begin n_fail++; $display("FAIL coll_set_wins: got %0b expected 1", rs2_pending); end
        rs1_address = 5'd0;
        issue_valid = 1'b1; issue_rd_address = 5'd0;
        step();
        issue_valid = 1'b0;
        n_checks++; if (rs1_pending !== 1'b0) begin n_fail++; $display("FAIL x0_never_pending: got %0b expected 0", rs1_pending); end
        alu_valid = 1'b1; alu_rd_address = 5'd9; alu_data = 32'h0000_0099;
        step();
        alu_valid = 1'b0;
        n_checks++; if (rs2_pending !== 1'b1) begin n_fail++; $display("FAIL coll_pending_before_commit: got %0b expected 1", rs2_pending); end
        step();
        n_checks++; if (rs2_pending !== 1'b0) begin n_fail++; $display("FAIL coll_pending_cleared: got %0b expected 0", rs2_pending); end
        n_checks++; if (rs1_pending !== 1'b0) begin n_fail++; $display("FAIL x0_pending_after: got %0b expected 0", rs1_pending); end
    endtask

    task automatic test_x0_load();
        alu_valid = 1'b1; alu_rd_address = 5'd11; alu_data = 32'h0000_0011;
        mem_valid = 1'b1; mem_rd_address = 5'd3; mem_data = 32'h0000_0033;
        step();
        n_checks++; if (queue_count !== 3'd1) begin n_fail++; $display("FAIL x0_pre_count: got %0d expected 1", queue_count); end
        alu_rd_address = 5'd12; alu_data = 32'h0000_0012;
        mem_rd_address = 5'd0; mem_data = 32'h0000_0044;
        #1;
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %0b expected 1", mem_ready); end
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        n_checks++; if (rd_address !== 5'd12) begin n_fail++; $display("FAIL x0_alu_rd: got %0d expected 12", rd_address); end
        n_checks++; if (queue_count !== 3'd1) begin n_fail++; $display("FAIL x0_count_unchanged: got %0d expected 1", queue_count); end
        step();
        n_checks++; if (rd_address !== 5'd3) begin n_fail++; $display("FAIL x0_queued_rd: got %0d expected 3", rd_address); end
        n_checks++; if (rd_data !== 32'h0000_0033) begin n_fail++; $display("FAIL x0_queued_data: got %0h expected 33", rd_data); end
        n_checks++; if (queue_count !== 3'd0) begin n_fail++; $display("FAIL x0_drained: got %0d expected 0", queue_count); end
        mem_valid = 1'b1; mem_rd_address = 5'd0; mem_data = 32'h0000_0077;
        step();
        mem_valid = 1'b0;
        n_checks++; if (rd_address !== 5'd0) begin n_fail++; $display("FAIL x0_no_write: got %0d expected 0", rd_address); end
        n_checks++; if (rd_data !== 32'h0000_0033) begin n_fail++; $display("FAIL x0_data_hold: got %0h expected 33", rd_data); end
        n_checks++; if (queue_count !== 3'd0) begin n_fail++; $display("FAIL x0_empty_count: got %0d expected 0", queue_count); end
    endtask

    task automatic test_reset_mid();
        rs1_address = 5'd4; rs2_address = 5'd8;
        for (int i = 0; i < 3; i++) begin
            issue_valid = (i < 2);
            issue_rd_address = (i == 0) ? 5'd4 : 5'd8;
            alu_valid = 1'b1; alu_rd_address = 5'(20 + i); alu_data = 32'h0000_0020 + 32'(i);
            mem_valid = 1'b1; mem_rd_address = 5'(i + 1); mem_data = 32'h0000_00C0 + 32'(i);
            step();
        end
        issue_valid = 1'b0;
        n_checks++; if (queue_count !== 3'd3) begin n_fail++; $display("FAIL rst_pre_count: got %0d expected 3", queue_count); end
        n_checks++; if (rs1_pending !== 1'b1) begin n_fail++; $display("FAIL rst_pre_pending4: got %0b expected 1", rs1_pending); end
        n_checks++; if (rs2_pending !== 1'b1) begin n_fail++; $display("FAIL rst_pre_pending8: got %0b expected 1", rs2_pending); end
        rst_n = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %0b expected 0", mem_ready); end
        step();
        n_checks++; if (queue_count !== 3'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 0", queue_count); end
        n_checks++; if (rd_address !== 5'd0) begin n_fail++; $display("FAIL rst_mid_rd_address: got %0d expected 0", rd_address); end
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL rst_mid_rd_data: got %0h expected 0", rd_data); end
        n_checks++; if (rs1_pending !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pending4: got %0b expected 0", rs1_pending); end
        n_checks++; if (rs2_pending !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pending8: got %0b expected 0", rs2_pending); end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (rd_address !== 5'd0 || queue_count !== 3'd0) begin n_fail++; $display("FAIL rst_no_stale[%0d]: got rd=%0d cnt=%0d expected rd=0 cnt=0", i, rd_address, queue_count); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_bypass();
        test_queue_fill();
        test_collision();
        test_x0_load();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
